// File: rtl/alu_181_pkg.sv
// Shared types and constants for the multi-cycle 74181-style ALU.
// Holds the sequencing states, common function selects and the slice-count helper.
package alu_181_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Arithmetic selects are used with M=0, logic selects with M=1.
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_XOR = 4'b0110;
    localparam logic [3:0] S_AND = 4'b1011;

    function automatic int slices_of(input int width);
        return width / 4;
    endfunction

endpackage

// File: rtl/alu_181_slice.sv
// Combinational 4-bit 74181 slice, active-high data, active-low carry in/out (Cn, Cn+4).
// Also reports the true carry into bit 3 so the top can derive signed overflow.
module alu_181_slice
(
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cn,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] f,
    output logic       cn4,
    output logic       c3
);

    logic [3:0] t1;
    logic [3:0] t2;
    logic [4:0] sum;
    logic [3:0] low_sum;

    // Arithmetic result is t1 plus t2 plus carry; logic result is the XNOR of the two terms.
    always_comb begin
        t1      = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        t2      = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        sum     = {1'b0, t1} + {1'b0, t2} + {4'b0000, ~cn};
        low_sum = {1'b0, t1[2:0]} + {1'b0, t2[2:0]} + {3'b000, ~cn};
        f       = sum[3:0];
        cn4     = ~sum[4];
        c3      = low_sum[3];
        if (m) begin
            f   = ~(t1 ^ t2);
            cn4 = 1'b1;
            c3  = 1'b0;
        end
    end

endmodule

// File: rtl/alu_181_wide.sv
// WIDTH-bit 74181 ALU evaluating one 4-bit slice per clock, LSB nibble first, with valid/ready handshakes.
// Define ALU_181_FLAGS_EN to build the zero and signed-overflow flags; otherwise they read 0.
module alu_181_wide
    import alu_181_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       S_selection_i,
    input  logic             mode_control_i,
    input  logic             carry_in_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] F_o,
    output logic             carry_out_o,
    output logic             A_eq_B_o,
    output logic             zero_o,
    output logic             overflow_o
);

    localparam int SLICES = slices_of(WIDTH);
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
            $error("alu_181_wide: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       s_q;
    logic             m_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] f_q;
    logic [WIDTH-1:0] f_next;
    logic             cout_q;
    logic             a_eq_b_q;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       slice_f;
    logic             slice_cn;
    logic             slice_cn4;
    logic             slice_c3;
    logic             slice_cout;
    logic             capture;
    logic             last_slice;

    assign capture    = (state_q == IDLE) && valid_i;
    assign last_slice = (state_q == RUN) && (idx_q == LAST_IDX);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Carries are meaningless in logic mode, so Cn and the carry out are held at 0 there.
    always_comb begin
        a_nib      = a_q[{idx_q, 2'b00} +: 4];
        b_nib      = b_q[{idx_q, 2'b00} +: 4];
        f_next     = f_q;
        f_next[{idx_q, 2'b00} +: 4] = slice_f;
        slice_cn   = m_q ? 1'b0 : ~carry_q;
        slice_cout = m_q ? 1'b0 : ~slice_cn4;
    end

    alu_181_slice u_slice (
        .s   (s_q),
        .m   (m_q),
        .cn  (slice_cn),
        .a   (a_nib),
        .b   (b_nib),
        .f   (slice_f),
        .cn4 (slice_cn4),
        .c3  (slice_c3)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            idx_q    <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            f_q      <= '0;
            cout_q   <= 1'b0;
            a_eq_b_q <= 1'b0;
        end else if (capture) begin
            idx_q   <= '0;
            s_q     <= S_selection_i;
            m_q     <= mode_control_i;
            carry_q <= carry_in_i;
            a_q     <= A_i;
            b_q     <= B_i;
        end else if (state_q == RUN) begin
            f_q     <= f_next;
            carry_q <= slice_cout;
            idx_q   <= idx_q + 1'b1;
            if (last_slice) begin
                cout_q   <= slice_cout;
                a_eq_b_q <= &f_next;
            end
        end
    end

`ifdef ALU_181_FLAGS_EN
    logic zero_q;
    logic ovf_q;

    // Overflow compares the carry into the MSB with the carry out of it.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (last_slice) begin
            zero_q <= (f_next == '0);
            ovf_q  <= m_q ? 1'b0 : (slice_c3 ^ slice_cout);
        end
    end

    assign zero_o     = zero_q;
    assign overflow_o = ovf_q;
`else
    logic unused_c3;
    assign unused_c3  = slice_c3;
    assign zero_o     = 1'b0;
    assign overflow_o = 1'b0;
`endif

    assign ready_o     = (state_q == IDLE);
    assign valid_o     = (state_q == DONE);
    assign F_o         = f_q;
    assign carry_out_o = cout_q;
    assign A_eq_B_o    = a_eq_b_q;

endmodule

// File: tb/tb_alu_181_wide.sv
// Directed self-checking bench for alu_181_wide at WIDTH=16.
// Flag expectations follow ALU_181_FLAGS_EN so the bench suits either build.
module tb_alu_181_wide;
    import alu_181_pkg::*;

    localparam int WIDTH = 16;

`ifdef ALU_181_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid_in;
    logic             ready_out;
    logic [3:0]       sel;
    logic             mode;
    logic             cin;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             valid_out;
    logic             ready_in;
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             a_eq_b;
    logic             zero;
    logic             ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_181_wide #(.WIDTH(WIDTH)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .valid_i        (valid_in),
        .ready_o        (ready_out),
        .S_selection_i  (sel),
        .mode_control_i (mode),
        .carry_in_i     (cin),
        .A_i            (op_a),
        .B_i            (op_b),
        .valid_o        (valid_out),
        .ready_i        (ready_in),
        .F_o            (f),
        .carry_out_o    (cout),
        .A_eq_B_o       (a_eq_b),
        .zero_o         (zero),
        .overflow_o     (ovf)
    );

    // Called #1 after an edge with the DUT idle; scrambles inputs after capture to prove they are ignored.
    task automatic apply_stimulus(input logic [3:0] s, input logic m, input logic c,
                                  input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  output int lat);
        sel = s; mode = m; cin = c; op_a = a; op_b = b; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        sel = ~s; mode = ~m; cin = ~c; op_a = ~a; op_b = b ^ 16'h5A5A;
        lat = 0;
        while (valid_out !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic accept_result();
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_in = 1'b1; ready_in = 1'b0;
        sel = S_ADD; mode = 1'b0; cin = 1'b1; op_a = 16'hFFFF; op_b = 16'h0001;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", valid_out); end
        checks++; if (f !== 16'h0000) begin failures++; $display("[TB] FAIL reset_f got=%h exp=0000", f); end
        checks++; if ({cout, a_eq_b, zero, ovf} !== 4'b0000) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=0000", {cout, a_eq_b, zero, ovf}); end
        checks++; if (ready_out !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", ready_out); end
        rst_n = 1'b1; valid_in = 1'b0;
        @(posedge clk); #1;
        checks++; if (ready_out !== 1'b1) begin failures++; $display("[TB] FAIL reset_no_capture got=%b exp=1", ready_out); end
    endtask

    task automatic test_add();
        int lat;
        apply_stimulus(S_ADD, 1'b0, 1'b0, 16'h1234, 16'h0FCD, lat);
        checks++; if (lat !== 4) begin failures++; $display("[TB] FAIL add_latency got=%0d exp=4", lat); end
        checks++; if (f !== 16'h2201) begin failures++; $display("[TB] FAIL add_f got=%h exp=2201", f); end
        checks++; if (cout !== 1'b0) begin failures++; $display("[TB] FAIL add_cout got=%b exp=0", cout); end
        checks++; if (a_eq_b !== 1'b0) begin failures++; $display("[TB] FAIL add_aeqb got=%b exp=0", a_eq_b); end
        accept_result();
        // A + cin with all ones ripples the carry through every slice.
        apply_stimulus(4'b0000, 1'b0, 1'b1, 16'hFFFF, 16'h1234, lat);
        checks++; if (f !== 16'h0000) begin failures++; $display("[TB] FAIL inc_f got=%h exp=0000", f); end
        checks++; if (cout !== 1'b1) begin failures++; $display("[TB] FAIL inc_cout got=%b exp=1", cout); end
        accept_result();
    endtask

    task automatic test_subtract();
        int lat;
        apply_stimulus(S_SUB, 1'b0, 1'b1, 16'h0005, 16'h0007, lat);
        checks++; if (f !== 16'hFFFE) begin failures++; $display("[TB] FAIL sub_f got=%h exp=fffe", f); end
        checks++; if (cout !== 1'b0) begin failures++; $display("[TB] FAIL sub_borrow got=%b exp=0", cout); end
        checks++; if (a_eq_b !== 1'b0) begin failures++; $display("[TB] FAIL sub_aeqb got=%b exp=0", a_eq_b); end
        accept_result();
        apply_stimulus(S_SUB, 1'b0, 1'b0, 16'h1234, 16'h1234, lat);
        checks++; if (f !== 16'hFFFF) begin failures++; $display("[TB] FAIL cmp_f got=%h exp=ffff", f); end
        checks++; if (a_eq_b !== 1'b1) begin failures++; $display("[TB] FAIL cmp_aeqb got=%b exp=1", a_eq_b); end
        accept_result();
    endtask

    task automatic test_logic();
        int lat;
        apply_stimulus(S_XOR, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, lat);
        checks++; if (f !== 16'h0FF0) begin failures++; $display("[TB] FAIL xor_f got=%h exp=0ff0", f); end
        checks++; if (cout !== 1'b0) begin failures++; $display("[TB] FAIL xor_cout got=%b exp=0", cout); end
        accept_result();
        apply_stimulus(S_AND, 1'b1, 1'b0, 16'h1234, 16'h0FF0, lat);
        checks++; if (f !== 16'h0230) begin failures++; $display("[TB] FAIL and_f got=%h exp=0230", f); end
        accept_result();
        apply_stimulus(4'b1100, 1'b1, 1'b0, 16'h0000, 16'h0000, lat);
        checks++; if ({f, a_eq_b, ovf} !== {16'hFFFF, 1'b1, 1'b0}) begin failures++; $display("[TB] FAIL ones_f got=%h/%b/%b exp=ffff/1/0", f, a_eq_b, ovf); end
        accept_result();
    endtask

    task automatic test_flags();
        int lat;
        apply_stimulus(S_ADD, 1'b0, 1'b0, 16'h7FFF, 16'h0001, lat);
        checks++; if (f !== 16'h8000) begin failures++; $display("[TB] FAIL ovf_f got=%h exp=8000", f); end
        checks++; if (ovf !== FLAGS) begin failures++; $display("[TB] FAIL ovf_flag got=%b exp=%b", ovf, FLAGS); end
        checks++; if (zero !== 1'b0) begin failures++; $display("[TB] FAIL ovf_zero got=%b exp=0", zero); end
        accept_result();
        apply_stimulus(S_ADD, 1'b0, 1'b0, 16'hFFFF, 16'h0001, lat);
        checks++; if (f !== 16'h0000) begin failures++; $display("[TB] FAIL wrap_f got=%h exp=0000", f); end
        checks++; if (cout !== 1'b1) begin failures++; $display("[TB] FAIL wrap_cout got=%b exp=1", cout); end
        checks++; if (zero !== FLAGS) begin failures++; $display("[TB] FAIL wrap_zero got=%b exp=%b", zero, FLAGS); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL wrap_ovf got=%b exp=0", ovf); end
        accept_result();
    endtask

    task automatic test_backpressure();
        int lat;
        apply_stimulus(S_ADD, 1'b0, 1'b1, 16'h00FF, 16'h0F01, lat);
        // New requests offered while DONE must not disturb the held result.
        valid_in = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({valid_out, ready_out, f, cout} !== {1'b1, 1'b0, 16'h1001, 1'b0}) begin
                failures++;
                $display("[TB] FAIL hold_cycle%0d got=%b/%b/%h/%b exp=1/0/1001/0", i, valid_out, ready_out, f, cout);
            end
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        accept_result();
        checks++; if ({valid_out, ready_out} !== 2'b01) begin failures++; $display("[TB] FAIL release_state got=%b exp=01", {valid_out, ready_out}); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        sel = S_ADD; mode = 1'b0; cin = 1'b0; op_a = 16'h4321; op_b = 16'h1111; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if ({valid_out, ready_out, f} !== {1'b0, 1'b1, 16'h0000}) begin failures++; $display("[TB] FAIL midrun_reset got=%b/%b/%h exp=0/1/0000", valid_out, ready_out, f); end
        apply_stimulus(S_ADD, 1'b0, 1'b0, 16'h00FF, 16'h0001, lat);
        checks++; if (lat !== 4) begin failures++; $display("[TB] FAIL midrun_latency got=%0d exp=4", lat); end
        checks++; if ({f, cout} !== {16'h0100, 1'b0}) begin failures++; $display("[TB] FAIL midrun_f got=%h/%b exp=0100/0", f, cout); end
        accept_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        apply_stimulus(S_SUB, 1'b0, 1'b1, 16'h1000, 16'h0001, lat);
        checks++; if ({f, cout} !== {16'h0FFF, 1'b1}) begin failures++; $display("[TB] FAIL b2b_first got=%h/%b exp=0fff/1", f, cout); end
        accept_result();
        checks++; if (ready_out !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready got=%b exp=1", ready_out); end
        apply_stimulus(S_ADD, 1'b0, 1'b1, 16'h8000, 16'h8000, lat);
        checks++; if (lat !== 4) begin failures++; $display("[TB] FAIL b2b_latency got=%0d exp=4", lat); end
        checks++; if ({f, cout} !== {16'h0001, 1'b1}) begin failures++; $display("[TB] FAIL b2b_second got=%h/%b exp=0001/1", f, cout); end
        checks++; if (ovf !== FLAGS) begin failures++; $display("[TB] FAIL b2b_ovf got=%b exp=%b", ovf, FLAGS); end
        accept_result();
    endtask

    initial begin
        test_reset();
        test_add();
        test_subtract();
        test_logic();
        test_flags();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_181_wide.md
# alu_181_wide

Parametrised, multi-cycle successor to the 4-bit 74181 ALU. It executes any 74181 function (16 logic, 16 arithmetic) on WIDTH-bit operands. One 4-bit slice is evaluated per clock, least-significant nibble first, with the ripple carry held in a register between slices. Operands enter and results leave through valid/ready handshakes, so the block can sit between a register file and a result bus.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, at least 4. SLICES = WIDTH/4.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_n_i  in  1  synchronous, active-low reset.
- valid_i  in  1  operation request.
- ready_o  out  1  block can accept a request.
- S_selection_i  in  4  74181 function select, active-high.
- mode_control_i  in  1  M: 1 = logic, 0 = arithmetic.
- carry_in_i  in  1  true carry: 1 adds one to the arithmetic result.
- A_i, B_i  in  WIDTH  operands.
- valid_o  out  1  result available.
- ready_i  in  1  consumer accepts the result.
- F_o  out  WIDTH  result.
- carry_out_o  out  1  true carry out of the MSB; 0 in logic mode.
- A_eq_B_o  out  1  F_o is all ones.
- zero_o  out  1  F_o == 0 (feature-gated).
- overflow_o  out  1  signed overflow (feature-gated).

## Operation
- FSM states:
  - IDLE: ready_o=1.
  - RUN: ready_o=0, valid_o=0.
  - DONE: valid_o=1.
- IDLE -> RUN on valid_i && ready_o:
  - latch S, M, carry_in_i, A_i and B_i.
  - set slice index to 0; carry register <= carry_in_i.
- RUN, each cycle:
  - evaluate slice[idx] on the latched nibbles and the carry register.
  - write the result nibble into F[4*idx+3:4*idx].
  - carry register <= slice carry out; idx++.
  - after slice SLICES-1, go to DONE.
- DONE: F_o and the flags stay stable until ready_i. On valid_o && ready_i, go to IDLE.
- Carry arithmetic:
  - internal Cn = ~carry register.
  - carry_out_o = carry out of the last slice.
  - both forced to 0 in logic mode.
  - subtraction: carry_out_o=1 means no borrow.
- Input changes while in RUN or DONE are ignored.
- A_eq_B_o = &F; valid in both modes.
- Reset (rst_n_i=0 at an edge), from any state including mid-RUN:
  - state <= IDLE; any in-flight operation is discarded.
  - F_o=0, carry_out_o=0, A_eq_B_o=0, zero_o=0, overflow_o=0, valid_o=0.
  - ready_o=1 in the first cycle after reset release.
  - A request presented during reset is not accepted.

## Timing
- The capture edge is E0. Slices are computed at edges E1..E_SLICES. valid_o is high in the cycle after E_SLICES, i.e. SLICES cycles after E0 (4 for WIDTH=16).
- Minimum issue interval is SLICES+2 cycles (capture, SLICES RUN cycles, DONE handshake). There is no overlap of consecutive operations.
- ready_o and valid_o are decoded from registered state only, with no combinational path from valid_i or ready_i.
- Outputs are registered and stable for the whole DONE residency.

## Configuration
- ALU_181_FLAGS_EN defined:
  - zero_o = (F == 0).
  - overflow_o = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, in arithmetic mode; 0 in logic mode.
  - Both are registered with F.
- ALU_181_FLAGS_EN undefined: the ports remain and are tied to 0; no flag logic is synthesised.

## Structure
- Package alu_181_pkg holds:
  - the state enum (IDLE, RUN, DONE).
  - localparams for common selects: S_ADD=4'b1001, S_SUB=4'b0110, S_XOR=4'b0110 (M=1), S_AND=4'b1011 (M=1).
  - a function computing SLICES from WIDTH.
- Sub-module alu_181_slice: a combinational 4-bit 74181 (S, M, Cn, A, B -> F, Cn+4, carry into bit 3). The top instantiates it once and time-multiplexes it across slices.
- Elaboration assertion: WIDTH % 4 == 0.

## Test plan
All scenarios use WIDTH=16.
- Reset: hold rst_n_i=0 for 3 cycles with valid_i=1. Expect all outputs 0 and no capture; after release, ready_o=1.
- Add: S=1001, M=0, cin=0, A=0x1234, B=0x0FCD. Expect F_o=0x2201, carry_out_o=0, valid_o exactly 4 cycles after capture.
- Subtract: S=0110, M=0, cin=1, A=0x0005, B=0x0007. Expect F_o=0xFFFE, carry_out_o=0 (borrow), A_eq_B_o=0. With A=B=0x1234 and cin=0, expect F_o=0xFFFF and A_eq_B_o=1.
- Logic XOR: S=0110, M=1, cin=1, A=0xF0F0, B=0xFF00. Expect F_o=0x0FF0, carry_out_o=0.
- Flags (macro on): 0x7FFF + 0x0001 -> F_o=0x8000, overflow_o=1, zero_o=0. 0xFFFF + 0x0001 -> F_o=0, carry_out_o=1, zero_o=1, overflow_o=0. With the macro off, both flags read 0.
- Backpressure: hold ready_i=0 for 5 cycles in DONE; outputs must stay stable and ready_o=0. Separately, pull rst_n_i low during RUN: the next cycle must be IDLE with valid_o=0, and a fresh operation must complete correctly.
